// File: rtl/regfile_writeback.sv
// Write-port controller for the register file: merges ALU, load and mul/div results into one write per cycle.
// Optional macro REGFILE_WB_FORWARD_EN drives the fwd_* bypass copy of the registered write.
module regfile_writeback #(
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 0,
  localparam int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [31:0]       alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [ADDR_W-1:0] md_addr,
  input  logic [31:0]       md_data,
  output logic              rf_wren,
  output logic [ADDR_W-1:0] rf_wraddress,
  output logic [31:0]       rf_data,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [31:0]       fwd_data,
  output logic [15:0]       stall_count
);

  logic [1:0]        rst_sync_r;
  logic              rst_n_s;

  logic              lh_full_r;
  logic [ADDR_W-1:0] lh_addr_r;
  logic [31:0]       lh_data_r;
  logic              mh_full_r;
  logic [ADDR_W-1:0] mh_addr_r;
  logic [31:0]       mh_data_r;
  logic              rr_md_r;

  logic              grant_ld_s;
  logic              grant_md_s;
  logic              ld_take_s;
  logic              md_take_s;
  logic              wr_valid_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [31:0]       wr_data_s;
  logic              both_full_s;

  // Reset synchronizer: assertion is immediate, release is aligned to clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  assign both_full_s = lh_full_r && mh_full_r;

  // Arbitration: ALU first, then round-robin between the two holding registers.
  always_comb begin
    grant_ld_s = 1'b0;
    grant_md_s = 1'b0;
    wr_valid_s = 1'b0;
    wr_addr_s  = {ADDR_W{1'b0}};
    wr_data_s  = 32'h0000_0000;
    if (alu_valid) begin
      wr_valid_s = 1'b1;
      wr_addr_s  = alu_addr;
      wr_data_s  = alu_data;
    end else if (lh_full_r && (!mh_full_r || !rr_md_r)) begin
      grant_ld_s = 1'b1;
      wr_valid_s = 1'b1;
      wr_addr_s  = lh_addr_r;
      wr_data_s  = lh_data_r;
    end else if (mh_full_r) begin
      grant_md_s = 1'b1;
      wr_valid_s = 1'b1;
      wr_addr_s  = mh_addr_r;
      wr_data_s  = mh_data_r;
    end else begin
      wr_valid_s = 1'b0;
    end
  end

  // Ready depends only on occupancy and this cycle's grant, so a drain frees the slot for a same-edge capture.
  assign ld_ready  = !lh_full_r || grant_ld_s;
  assign md_ready  = !mh_full_r || grant_md_s;
  assign ld_take_s = ld_valid && ld_ready;
  assign md_take_s = md_valid && md_ready;

  // Load holding register.
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      lh_full_r <= 1'b0;
      lh_addr_r <= {ADDR_W{1'b0}};
      lh_data_r <= 32'h0000_0000;
    end else if (ld_take_s) begin
      lh_full_r <= 1'b1;
      lh_addr_r <= ld_addr;
      lh_data_r <= ld_data;
    end else if (grant_ld_s) begin
      lh_full_r <= 1'b0;
    end
  end

  // Mul/div holding register.
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      mh_full_r <= 1'b0;
      mh_addr_r <= {ADDR_W{1'b0}};
      mh_data_r <= 32'h0000_0000;
    end else if (md_take_s) begin
      mh_full_r <= 1'b1;
      mh_addr_r <= md_addr;
      mh_data_r <= md_data;
    end else if (grant_md_s) begin
      mh_full_r <= 1'b0;
    end
  end

  // Round-robin pointer toggles only when it actually resolved a contention.
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      rr_md_r <= 1'b0;
    end else if (!alu_valid && both_full_s) begin
      rr_md_r <= !rr_md_r;
    end
  end

  // Registered write port; hard-wired zero register consumes its grant but never strobes wren.
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      rf_wren      <= 1'b0;
      rf_wraddress <= {ADDR_W{1'b0}};
      rf_data      <= 32'h0000_0000;
    end else begin
      rf_wren <= wr_valid_s && (wr_addr_s != ADDR_W'(ZERO_REG));
      if (wr_valid_s) begin
        rf_wraddress <= wr_addr_s;
        rf_data      <= wr_data_s;
      end
    end
  end

  // Saturating count of cycles a buffered slow-unit result lost to the ALU.
  always_ff @(posedge clock or negedge rst_n_s) begin
    if (!rst_n_s) begin
      stall_count <= 16'h0000;
    end else if (alu_valid && (lh_full_r || mh_full_r) && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'h0001;
    end
  end

`ifdef REGFILE_WB_FORWARD_EN
  assign fwd_valid = rf_wren;
  assign fwd_addr  = rf_wraddress;
  assign fwd_data  = rf_data;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = {ADDR_W{1'b0}};
  assign fwd_data  = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: expected writes queued at stimulus time, popped on each rf_wren.
module tb_regfile_writeback;

  logic        clock;
  logic        reset_n;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        rf_wren;
  logic [4:0]  rf_wraddress;
  logic [31:0] rf_data;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic [15:0] stall_count;

  int checks;
  int errors;
  logic [36:0] sb[$];
  logic [36:0] exp_w;

  regfile_writeback dut (
    .clock(clock), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data),
    .rf_wren(rf_wren), .rf_wraddress(rf_wraddress), .rf_data(rf_data),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .stall_count(stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clock) begin
    if (reset_n && rf_wren === 1'b1) begin
      checks = checks + 1;
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_write got addr=%0d data=%h required no write", rf_wraddress, rf_data);
      end else begin
        exp_w = sb.pop_front();
        if ({rf_wraddress, rf_data} !== exp_w) begin
          errors = errors + 1;
          $display("FAIL sb_write got addr=%0d data=%h required addr=%0d data=%h",
                   rf_wraddress, rf_data, exp_w[36:32], exp_w[31:0]);
        end
      end
`ifdef REGFILE_WB_FORWARD_EN
      checks = checks + 1;
      if ({fwd_valid, fwd_addr, fwd_data} !== {1'b1, rf_wraddress, rf_data}) begin
        errors = errors + 1;
        $display("FAIL fwd_copy got %b/%0d/%h required 1/%0d/%h", fwd_valid, fwd_addr, fwd_data, rf_wraddress, rf_data);
      end
`else
      checks = checks + 1;
      if ({fwd_valid, fwd_addr, fwd_data} !== 38'd0) begin
        errors = errors + 1;
        $display("FAIL fwd_tied got %b/%0d/%h required 0/0/0", fwd_valid, fwd_addr, fwd_data);
      end
`endif
    end
  end

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_addr = 5'd0; alu_data = 32'd0;
    ld_valid  = 1'b0; ld_addr  = 5'd0; ld_data  = 32'd0;
    md_valid  = 1'b0; md_addr  = 5'd0; md_data  = 32'd0;
  endtask

  // Leaves the bench at posedge+1, ready to drive the first cycle.
  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    checks = checks + 1;
    if ({rf_wren, rf_wraddress, rf_data, fwd_valid, fwd_addr, fwd_data, stall_count} !== 92'd0) begin
      errors = errors + 1;
      $display("FAIL reset_outputs got wren=%b addr=%0d data=%h fwd=%b stall=%0d required all 0",
               rf_wren, rf_wraddress, rf_data, fwd_valid, stall_count);
    end
    checks = checks + 1;
    if ({ld_ready, md_ready} !== 2'b11) begin
      errors = errors + 1;
      $display("FAIL reset_ready got ld=%b md=%b required 1 1", ld_ready, md_ready);
    end
    next_cycle();
  endtask

  task automatic test_alu_write();
    sb.push_back({5'd5, 32'h1234_5678});
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234_5678;
    next_cycle();
    alu_valid = 1'b0;
    @(negedge clock);
    checks = checks + 1;
    if ({rf_wren, rf_wraddress, rf_data} !== {1'b1, 5'd5, 32'h1234_5678}) begin
      errors = errors + 1;
      $display("FAIL alu_latency got wren=%b addr=%0d data=%h required 1 5 12345678", rf_wren, rf_wraddress, rf_data);
    end
    next_cycle();
    @(negedge clock);
    checks = checks + 1;
    if (rf_wren !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL alu_pulse got wren=%b required 0", rf_wren);
    end
    next_cycle();
  endtask

  task automatic test_alu_stall_load();
    do_reset();
    for (int i = 1; i <= 4; i++) sb.push_back({5'(9 + i), 32'hA100_0000 + 32'(i)});
    sb.push_back({5'd7, 32'h0000_00AA});
    ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 32'h0000_00AA;
    @(negedge clock);
    checks = checks + 1;
    if (ld_ready !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL stall_capture_ready got %b required 1", ld_ready);
    end
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      ld_valid = 1'b0;
      alu_valid = 1'b1; alu_addr = 5'(9 + i); alu_data = 32'hA100_0000 + 32'(i);
      @(negedge clock);
      checks = checks + 1;
      if (ld_ready !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL stall_ready_low cycle=%0d got %b required 0", i, ld_ready);
      end
    end
    next_cycle();
    alu_valid = 1'b0;
    @(negedge clock);
    checks = checks + 1;
    if (ld_ready !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL stall_drain_ready got %b required 1", ld_ready);
    end
    next_cycle();
    @(negedge clock);
    checks = checks + 1;
    if ({rf_wren, rf_wraddress, rf_data} !== {1'b1, 5'd7, 32'h0000_00AA}) begin
      errors = errors + 1;
      $display("FAIL stall_load_write got wren=%b addr=%0d data=%h required 1 7 aa", rf_wren, rf_wraddress, rf_data);
    end
    checks = checks + 1;
    if (stall_count !== 16'd4) begin
      errors = errors + 1;
      $display("FAIL stall_count got %0d required 4", stall_count);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      if (r == 0) begin
        sb.push_back({5'd3, 32'h0000_0300});
        sb.push_back({5'd4, 32'h0000_0400});
      end else begin
        sb.push_back({5'd4, 32'h0000_0401});
        sb.push_back({5'd3, 32'h0000_0301});
      end
      ld_valid = 1'b1; ld_addr = 5'd3; ld_data = 32'h0000_0300 + 32'(r);
      md_valid = 1'b1; md_addr = 5'd4; md_data = 32'h0000_0400 + 32'(r);
      next_cycle();
      ld_valid = 1'b0; md_valid = 1'b0;
      next_cycle();
      @(negedge clock);
      checks = checks + 1;
      if ({rf_wren, rf_wraddress} !== {1'b1, (r == 0) ? 5'd3 : 5'd4}) begin
        errors = errors + 1;
        $display("FAIL rr_first round=%0d got wren=%b addr=%0d required 1 %0d", r, rf_wren, rf_wraddress, (r == 0) ? 3 : 4);
      end
      next_cycle();
      @(negedge clock);
      checks = checks + 1;
      if ({rf_wren, rf_wraddress} !== {1'b1, (r == 0) ? 5'd4 : 5'd3}) begin
        errors = errors + 1;
        $display("FAIL rr_second round=%0d got wren=%b addr=%0d required 1 %0d", r, rf_wren, rf_wraddress, (r == 0) ? 4 : 3);
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 10; i++) begin
      if (i <= 8) begin
        sb.push_back({5'(i), 32'h0000_0100 + 32'(i)});
        ld_valid = 1'b1; ld_addr = 5'(i); ld_data = 32'h0000_0100 + 32'(i);
      end else begin
        ld_valid = 1'b0;
      end
      @(negedge clock);
      if (i <= 8) begin
        checks = checks + 1;
        if (ld_ready !== 1'b1) begin
          errors = errors + 1;
          $display("FAIL b2b_ready beat=%0d got %b required 1", i, ld_ready);
        end
      end
      if (i >= 3) begin
        checks = checks + 1;
        if ({rf_wren, rf_wraddress} !== {1'b1, 5'(i - 2)}) begin
          errors = errors + 1;
          $display("FAIL b2b_pulse beat=%0d got wren=%b addr=%0d required 1 %0d", i, rf_wren, rf_wraddress, i - 2);
        end
      end
      next_cycle();
    end
    @(negedge clock);
    checks = checks + 1;
    if (rf_wren !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL b2b_end got wren=%b required 0", rf_wren);
    end
    next_cycle();
  endtask

  task automatic test_zero_reg();
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFF_FFFF;
    next_cycle();
    alu_valid = 1'b0;
    @(negedge clock);
    checks = checks + 1;
    if ({rf_wren, rf_wraddress, rf_data, fwd_valid} !== {1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0}) begin
      errors = errors + 1;
      $display("FAIL zero_reg got wren=%b addr=%0d data=%h fwd=%b required 0 0 ffffffff 0",
               rf_wren, rf_wraddress, rf_data, fwd_valid);
    end
    next_cycle();
  endtask

  task automatic test_midop_reset_and_saturation();
    do_reset();
    ld_valid = 1'b1; ld_addr = 5'd7; ld_data = 32'h0000_0055;
    next_cycle();
    ld_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h0000_0099;
    next_cycle();
    alu_addr = 5'd0;
    checks = checks + 1;
    if ({rf_wren, rf_wraddress, ld_ready} !== {1'b1, 5'd9, 1'b0}) begin
      errors = errors + 1;
      $display("FAIL midop_setup got wren=%b addr=%0d ld_ready=%b required 1 9 0", rf_wren, rf_wraddress, ld_ready);
    end
    #1 reset_n = 1'b0;
    #1;
    checks = checks + 1;
    if ({rf_wren, ld_ready} !== 2'b01) begin
      errors = errors + 1;
      $display("FAIL midop_async got wren=%b ld_ready=%b required 0 1", rf_wren, ld_ready);
    end
    alu_valid = 1'b0;
    @(posedge clock);
    #3 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      checks = checks + 1;
      if ({rf_wren, ld_ready, stall_count} !== {1'b0, 1'b1, 16'd0}) begin
        errors = errors + 1;
        $display("FAIL midop_stale cycle=%0d got wren=%b ld_ready=%b stall=%0d required 0 1 0", i, rf_wren, ld_ready, stall_count);
      end
    end
    next_cycle();
    sb.push_back({5'd12, 32'h0000_000C});
    ld_valid = 1'b1; ld_addr = 5'd12; ld_data = 32'h0000_000C;
    next_cycle();
    ld_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hDEAD_0000;
    repeat (100) @(posedge clock);
    #1;
    @(negedge clock);
    checks = checks + 1;
    if (stall_count !== 16'd100) begin
      errors = errors + 1;
      $display("FAIL stall_partial got %0d required 100", stall_count);
    end
    repeat (70000) @(posedge clock);
    #1;
    @(negedge clock);
    checks = checks + 1;
    if (stall_count !== 16'hFFFF) begin
      errors = errors + 1;
      $display("FAIL stall_saturate got %h required ffff", stall_count);
    end
    next_cycle();
    alu_valid = 1'b0;
    next_cycle();
    @(negedge clock);
    checks = checks + 1;
    if ({rf_wren, rf_wraddress, stall_count} !== {1'b1, 5'd12, 16'hFFFF}) begin
      errors = errors + 1;
      $display("FAIL sat_drain got wren=%b addr=%0d stall=%h required 1 12 ffff", rf_wren, rf_wraddress, stall_count);
    end
    next_cycle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_alu_write();
    test_alu_stall_load();
    test_round_robin();
    test_back_to_back();
    test_zero_reg();
    test_midop_reset_and_saturation();
    repeat (3) @(posedge clock);
    #1;
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL sb_drained got %0d pending required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-port controller for the 32x32 register file: the initiator that drives the register file's single synchronous write port (wren/wraddress/data).
- Collects results from three producers and issues at most one register write per cycle:
  - ALU: fixed pipeline, cannot stall.
  - Load unit: valid/ready.
  - Mul/div unit: valid/ready.
- Sits between the execute/memory stages and the register file. Buffers slow-unit results so they never collide with ALU writes.

Parameters:
- NUM_REGS, 32, number of architectural registers. Address width is log2(NUM_REGS), 5 at default.
- ZERO_REG, 0, register index whose writes are discarded (hard-wired zero).

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present this cycle; always accepted.
- alu_addr  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  load holding register can accept.
- ld_addr  in  5  load destination register.
- ld_data  in  32  load result.
- md_valid  in  1  mul/div result offered.
- md_ready  out  1  mul/div holding register can accept.
- md_addr  in  5  mul/div destination register.
- md_data  in  32  mul/div result.
- rf_wren  out  1  register file write enable.
- rf_wraddress  out  5  register file write address.
- rf_data  out  32  register file write data.
- fwd_valid  out  1  forwarding copy of the write in flight (see optional feature).
- fwd_addr  out  5  forwarding address.
- fwd_data  out  32  forwarding data.
- stall_count  out  16  saturating count of cycles in which a slow-unit result waited because of the ALU.

Behaviour:
- Reset (async assert, release sync to clock): rf_wren=0, rf_wraddress=0, rf_data=0, fwd_*=0, stall_count=0, both holding registers empty, round-robin pointer = load. ld_ready=md_ready=1 after reset.
- Holding registers: one entry each for load (LH) and mul/div (MH).
  - Capture on valid&&ready.
  - ld_ready = !LH.full || LH drained this cycle. md_ready likewise for MH. Combinational from state and grant only, never from ld_valid/md_valid.
- Arbitration each cycle, ALU highest priority:
  - If alu_valid, ALU is granted and LH/MH hold.
  - Otherwise, if both LH and MH are full, the round-robin pointer picks one and then toggles to the other.
  - Otherwise, whichever single holding register is full is granted.
- Output register: the granted write appears on rf_wren/rf_wraddress/rf_data on the next rising edge. Latency is one cycle from alu_valid, or from capture into LH/MH when uncontended. rf_wren is held high for exactly one cycle per write.
- ZERO_REG filtering: a granted write with addr==ZERO_REG still consumes its grant and frees its holding register, but produces rf_wren=0. rf_wraddress/rf_data still update.
- Same-cycle capture and drain: if LH drains while ld_valid=1, the new result is captured in the same edge, giving back-to-back loads at full throughput when the ALU is idle.
- Same destination from two sources: writes are issued in grant order only. No merging and no reordering beyond arbitration. Producers own hazard ordering.
- stall_count: increments by 1 in any cycle where alu_valid=1 and (LH.full || MH.full). Saturates at 0xFFFF.
- Mid-operation reset: holding-register contents are lost, and rf_wren drops immediately (asynchronously).

Optional Feature:
- Macro: REGFILE_WB_FORWARD_EN.
- Defined: fwd_valid/fwd_addr/fwd_data equal the registered rf_wren/rf_wraddress/rf_data, so the decode stage can bypass a write landing this edge. fwd_valid is 0 for ZERO_REG writes.
- Undefined: fwd_valid, fwd_addr and fwd_data are tied to constant 0 and no extra logic is generated. All other behaviour is identical.

Test Plan:
- Reset, then alu_valid=1, alu_addr=5, alu_data=0x12345678 for 1 cycle -> next cycle rf_wren=1, rf_wraddress=5, rf_data=0x12345678. The following cycle rf_wren=0.
- alu_valid=1 for 4 cycles while ld_valid=1 (addr 7, data 0xAA) is captured in cycle 0 -> ld_ready=0 during cycles 1-4 and the load write appears after the ALU burst ends. stall_count=4.
- LH and MH both full (ld addr 3, md addr 4), ALU idle -> pointer at reset selects load first: addr 3, then addr 4 on the next cycle. Repeat with both full again -> mul/div wins first.
- ALU idle; ld_valid=1 for 8 consecutive cycles (addr 1..8) -> ld_ready stays 1 throughout and 8 consecutive rf_wren pulses carry addr 1..8 in order.
- alu_valid=1 with alu_addr=0, data 0xFFFFFFFF -> rf_wren stays 0, and fwd_valid=0 with REGFILE_WB_FORWARD_EN defined.
- Assert reset_n=0 mid-cycle while rf_wren=1 and LH full -> rf_wren=0 immediately. After release ld_ready=1 and no stale write is issued. Force alu_valid stall for 70000 cycles -> stall_count=0xFFFF.
